sample_window_buffer: RTL and testbench

SAMPLE_WINDOW_BUFFER -- requirements
Module: sample_window_buffer

---
 rtl/sample_window_buffer_pkg.sv | 17 +
 rtl/sample_window_buffer_if.sv | 46 ++++
 rtl/sample_window_buffer_ram.sv | 25 ++
 rtl/sample_window_buffer.sv | 129 ++++++++++++
 tb/tb_sample_window_buffer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/sample_window_buffer_pkg.sv
// tsp_pkg -- shared definitions for the sample window buffer.
//   Default WIDTH/DEPTH/WINDOW/STRIDE constants and the analysis FSM
//   state encoding, imported by the top and its interface.
package tsp_pkg;

  localparam int SWB_WIDTH  = 32;
  localparam int SWB_DEPTH  = 16;
  localparam int SWB_WINDOW = 10;
  localparam int SWB_STRIDE = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } swb_state_e;

endpackage

// File: rtl/sample_window_buffer_if.sv
// sample_window_buffer_if -- bundles the sample stream, the analysis
// handshake and the downstream read port of sample_window_buffer.
//   upstream  : in_valid, in_data -> ; <- in_ready
//   analysis  : <- start, si, ei, busy ; done ->
//   read port : index -> ; <- value
//   status    : <- occupancy (log2(DEPTH)+1 bits)
//   drop_count exists only when SWB_DROP_EN is defined.
// slave = the buffer, master = upstream/downstream environment.
interface sample_window_buffer_if #(
  parameter int WIDTH = tsp_pkg::SWB_WIDTH,
  parameter int DEPTH = tsp_pkg::SWB_DEPTH
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             start;
  logic [WIDTH-1:0] si;
  logic [WIDTH-1:0] ei;
  logic             done;
  logic [WIDTH-1:0] index;
  logic [WIDTH-1:0] value;
  logic [PW-1:0]    occupancy;
  logic             busy;
`ifdef SWB_DROP_EN
  logic [WIDTH-1:0] drop_count;
`endif

  modport slave (
    input  in_valid, in_data, done, index,
    output in_ready, start, si, ei, value, occupancy, busy
`ifdef SWB_DROP_EN
    , output drop_count
`endif
  );

  modport master (
    output in_valid, in_data, done, index,
    input  in_ready, start, si, ei, value, occupancy, busy
`ifdef SWB_DROP_EN
    , input drop_count
`endif
  );

endinterface

// File: rtl/sample_window_buffer_ram.sv
// swb_ram -- sample storage for sample_window_buffer.
//   One synchronous write port (clk_i, we_i, waddr_i, wdata_i) and one
//   asynchronous read port (raddr_i -> rdata_o). Contents are not reset.
module swb_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sample_window_buffer.sv
// sample_window_buffer -- circular sample buffer that hands fixed-size
// analysis windows to a downstream stage.
//   Clk : clock, rising edge.   Rst : asynchronous active-low reset.
//   bus : sample_window_buffer_if.slave (stream in, start/si/ei/done
//         analysis handshake, index/value read port, occupancy, busy).
// Once WINDOW samples are held, start pulses for one cycle with the
// window [si, ei); after done the window base advances by STRIDE.
// Optional build macro SWB_DROP_EN: in_ready tied high, samples arriving
// while full are discarded and counted in a saturating drop_count.
module sample_window_buffer
  import tsp_pkg::*;
#(
  parameter int WIDTH  = SWB_WIDTH,
  parameter int DEPTH  = SWB_DEPTH,
  parameter int WINDOW = SWB_WINDOW,
  parameter int STRIDE = SWB_STRIDE
) (
  input logic                  Clk,
  input logic                  Rst,
  sample_window_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] WINDOW_P = PW'(WINDOW);
  localparam logic [PW-1:0] STRIDE_P = PW'(STRIDE);

  swb_state_e       state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    base_q, base_d;
  logic [WIDTH-1:0] si_q, si_d;
  logic [WIDTH-1:0] ei_q, ei_d;
  logic [PW-1:0]    occ;
  logic             has_room;
  logic             accept;

  // One extra pointer bit lets occupancy distinguish full from empty.
  assign occ      = wr_ptr_q - base_q;
  assign has_room = (occ < DEPTH_P);
  assign accept   = bus.in_valid && has_room;

  // ---------------- storage ----------------
  swb_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (Clk),
    .we_i    (accept),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (bus.in_data),
    .raddr_i (bus.index[AW-1:0]),
    .rdata_o (bus.value)
  );

  // Upper read-index bits are deliberately ignored.
  logic unused_index;
  assign unused_index = ^bus.index[WIDTH-1:AW];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      base_q   <= '0;
      si_q     <= '0;
      ei_q     <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      base_q   <= base_d;
      si_q     <= si_d;
      ei_q     <= ei_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (occ >= WINDOW_P) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (bus.done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pointer and window bookkeeping. A write and a done in the same cycle
  // both apply, so occupancy moves by +1-STRIDE.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(accept);
    base_d   = base_q;
    si_d     = si_q;
    ei_d     = ei_q;
    if (state_q == ST_WAIT && bus.done) base_d = base_q + STRIDE_P;
    // Capture the window as ISSUE is entered; it then holds through WAIT.
    if (state_q == ST_IDLE && state_d == ST_ISSUE) begin
      si_d = WIDTH'(base_q[AW-1:0]);
      ei_d = WIDTH'(base_q[AW-1:0]) + WIDTH'(WINDOW);
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.start = (state_q == ST_ISSUE);
    bus.busy  = (state_q != ST_IDLE);
  end

  assign bus.si        = si_q;
  assign bus.ei        = ei_q;
  assign bus.occupancy = occ;

`ifdef SWB_DROP_EN
  logic [WIDTH-1:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (bus.in_valid && !has_room && drop_q != '1) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) drop_q <= '0;
    else      drop_q <= drop_d;
  end

  assign bus.in_ready   = 1'b1;
  assign bus.drop_count = drop_q;
`else
  assign bus.in_ready = has_room;
`endif

endmodule

// File: tb/tb_sample_window_buffer.sv
module tb_sample_window_buffer;

  logic Clk = 1'b0;
  logic Rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 Clk = ~Clk;

  sample_window_buffer_if #(.WIDTH(32), .DEPTH(16)) bus ();

  sample_window_buffer #(.WIDTH(32), .DEPTH(16), .WINDOW(10), .STRIDE(5)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] seq [10];
    seq = '{33, 23, 15, 12, 82, 64, 53, 58, 66, 39};
    Rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.done     = 1'b0;
    bus.index    = '0;
    step();
    step();
    chk("rst_occ",   32'(bus.occupancy), 32'd0);
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_si",    bus.si, 32'd0);
    chk("rst_ei",    bus.ei, 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    Rst = 1'b1;

    // first window: 10 samples, start the cycle after the 10th accept
    for (int i = 0; i < 10; i++) push(seq[i]);
    chk("w1_occ",       32'(bus.occupancy), 32'd10);
    chk("w1_nostart",   32'(bus.start), 32'd0);
    step();
    chk("w1_start",     32'(bus.start), 32'd1);
    chk("w1_busy",      32'(bus.busy), 32'd1);
    chk("w1_si",        bus.si, 32'd0);
    chk("w1_ei",        bus.ei, 32'd10);
    bus.index = 32'd4;
    #1;
    chk("w1_value4",    bus.value, 32'd82);
    step();
    chk("w1_pulse_end", 32'(bus.start), 32'd0);
    chk("w1_si_hold",   bus.si, 32'd0);

    // five more samples, then done -> base 5, next window 5..15
    for (int i = 0; i < 5; i++) push(32'd100 + 32'(i));
    chk("w2_occ15",  32'(bus.occupancy), 32'd15);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk("w2_occ10",  32'(bus.occupancy), 32'd10);
    chk("w2_idle",   32'(bus.busy), 32'd0);
    step();
    chk("w2_start",  32'(bus.start), 32'd1);
    chk("w2_si",     bus.si, 32'd5);
    chk("w2_ei",     bus.ei, 32'd15);
    // done during ISSUE is ignored
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk("w2_done_issue_occ",  32'(bus.occupancy), 32'd10);
    chk("w2_done_issue_busy", 32'(bus.busy), 32'd1);

    // six more samples -> full, then done -> window 10..20
    for (int i = 0; i < 6; i++) push(32'd200 + 32'(i));
    chk("w3_occ16",  32'(bus.occupancy), 32'd16);
    chk("w3_ready0", 32'(bus.in_ready), 32'd0);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk("w3_occ11",  32'(bus.occupancy), 32'd11);
    step();
    chk("w3_start",  32'(bus.start), 32'd1);
    chk("w3_si",     bus.si, 32'd10);
    chk("w3_ei",     bus.ei, 32'd20);
    bus.index = 32'd17;
    #1;
    chk("w3_value17", bus.value, 32'd202);

    // fill to 16 and hold a 17th sample under backpressure
    for (int i = 0; i < 5; i++) push(32'd300 + 32'(i));
    chk("bp_occ16",   32'(bus.occupancy), 32'd16);
    chk("bp_ready0",  32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h777;
    step();
    step();
    chk("bp_held_occ", 32'(bus.occupancy), 32'd16);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk("bp_after_done_occ",   32'(bus.occupancy), 32'd11);
    chk("bp_after_done_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_accept_occ", 32'(bus.occupancy), 32'd12);
    chk("bp_b2b_start",  32'(bus.start), 32'd1);
    chk("bp_b2b_si",     bus.si, 32'd15);
    chk("bp_b2b_ei",     bus.ei, 32'd25);
    bus.index = 32'd10;
    #1;
    chk("bp_value10",    bus.value, 32'h777);

    // write and done coincide at occupancy 12 -> 8
    step();
    chk("co_occ12", 32'(bus.occupancy), 32'd12);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h888;
    bus.done     = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.done     = 1'b0;
    chk("co_occ8",  32'(bus.occupancy), 32'd8);
    chk("co_idle",  32'(bus.busy), 32'd0);
    // done in IDLE is ignored
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk("idle_done_occ",  32'(bus.occupancy), 32'd8);
    chk("idle_done_busy", 32'(bus.busy), 32'd0);

    // window wrapping the buffer end (base 20 -> si 4), then reset in WAIT
    push(32'h901);
    push(32'h902);
    step();
    chk("wrap_start", 32'(bus.start), 32'd1);
    chk("wrap_si",    bus.si, 32'd4);
    chk("wrap_ei",    bus.ei, 32'd14);
    step();
    chk("wait_busy",  32'(bus.busy), 32'd1);
    Rst = 1'b0;
    #1;
    chk("mid_rst_occ",  32'(bus.occupancy), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_si",   bus.si, 32'd0);
    chk("mid_rst_ei",   bus.ei, 32'd0);
    chk("mid_rst_start", 32'(bus.start), 32'd0);
    chk("mem_kept",     bus.value, 32'h777);
    step();
    Rst = 1'b1;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk("post_rst_done_occ",  32'(bus.occupancy), 32'd0);
    chk("post_rst_done_busy", 32'(bus.busy), 32'd0);

`ifdef SWB_DROP_EN
    chk("drop_rst", bus.drop_count, 32'd0);
    for (int i = 0; i < 16; i++) push(32'd400 + 32'(i));
    chk("drop_occ16", 32'(bus.occupancy), 32'd16);
    chk("drop_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) push(32'hdead);
    chk("drop_occ_kept", 32'(bus.occupancy), 32'd16);
    chk("drop_count3",   bus.drop_count, 32'd3);
`else
    chk("nodrop_ready", 32'(bus.in_ready), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
